// File: rtl/seq_rgb_comparator.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Registered RGB result: R = a>b, G = a==b, B = a<b; cycles = bits examined.
module seq_rgb_comparator #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED     = 1'b0,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic                         R,
  output logic                         G,
  output logic                         B,
  output logic [$clog2(WIDTH+1)-1:0]   cycles
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            found_q, found_d;
  logic [2:0]      res_q, res_d;
  logic [2:0]      rgb_q, rgb_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            diff, first, finish;
  logic [2:0]      dec;

  // {R,G,B} for a differing bit; the sign bit inverts the sense in signed mode.
  function automatic logic [2:0] decide(input logic a_bit, input logic is_sign);
    logic a_wins;
    a_wins = (SIGNED && is_sign) ? ~a_bit : a_bit;
    return a_wins ? 3'b100 : 3'b001;
  endfunction

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    res_d    = res_q;
    rgb_d    = rgb_q;
    cycles_d = cycles_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff     = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];
    first    = diff && !found_q;
    finish   = (EARLY_EXIT && diff) || (cnt_q == CW'(WIDTH-1));
    dec      = decide(sa_q[WIDTH-1], cnt_q == '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          sa_d    = a;
          sb_d    = b;
          cnt_d   = '0;
          found_d = 1'b0;
          res_d   = 3'b010;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (first) begin
          found_d = 1'b1;
          res_d   = dec;
        end
        if (finish) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cycles_d = cnt_q + CW'(1);
          // Only the first differing bit decides; later differences are ignored.
          if (first)        rgb_d = dec;
          else if (found_q) rgb_d = res_q;
          else              rgb_d = 3'b010;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      res_q    <= 3'b000;
      rgb_q    <= 3'b000;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      res_q    <= res_d;
      rgb_q    <= rgb_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign R      = rgb_q[2];
  assign G      = rgb_q[1];
  assign B      = rgb_q[0];
  assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_rgb_comparator.sv
// Scoreboard bench for seq_rgb_comparator: five parameterisations share stimulus,
// a reference model predicts result, bit count and done timing for each.
module tb_seq_rgb_comparator;

  typedef struct {
    logic [2:0] rgb;
    int         n;
    int         e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;

  logic busy0, done0, r0, g0, bl0; logic [3:0] c0;
  logic busy1, done1, r1, g1, bl1; logic [3:0] c1;
  logic busy2, done2, r2, g2, bl2; logic [3:0] c2;
  logic busy3, done3, r3, g3, bl3; logic [1:0] c3;
  logic busy4, done4, r4, g4, bl4; logic [1:0] c4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb[5][$];
  logic [2:0] last_exp0 = 3'b000;

  seq_rgb_comparator #(.WIDTH(8), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy0), .done(done0), .R(r0), .G(g0), .B(bl0), .cycles(c0));
  seq_rgb_comparator #(.WIDTH(8), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy1), .done(done1), .R(r1), .G(g1), .B(bl1), .cycles(c1));
  seq_rgb_comparator #(.WIDTH(8), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy2), .done(done2), .R(r2), .G(g2), .B(bl2), .cycles(c2));
  seq_rgb_comparator #(.WIDTH(2), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u3 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy3), .done(done3), .R(r3), .G(g3), .B(bl3), .cycles(c3));
  seq_rgb_comparator #(.WIDTH(2), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u4 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy4), .done(done4), .R(r4), .G(g4), .B(bl4), .cycles(c4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer compare of the (optionally sign-extended) operands.
  function automatic exp_t model(input int w, input bit sg, input bit ee,
                                 input logic [7:0] a, input logic [7:0] b, input int e0);
    exp_t e;
    int ua, ub, va, vb, k;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    va = ua;
    vb = ub;
    if (sg && ua >= (1 << (w-1))) va = ua - (1 << w);
    if (sg && ub >= (1 << (w-1))) vb = ub - (1 << w);
    e.rgb = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
    e.n = w;
    if (ee && ua != ub) begin
      k = 0;
      for (int i = 0; i < w; i++) if (((ua ^ ub) >> i) & 1) k = i;
      e.n = w - k;
    end
    e.e0 = e0;
    return e;
  endfunction

  task automatic mon(input int id, input logic dn, input logic [2:0] rgb, input int cy);
    exp_t e;
    if (dn) begin
      if (sb[id].size() == 0) begin
        chk($sformatf("u%0d spurious done", id), 1, 0);
      end else begin
        e = sb[id].pop_front();
        if (id == 0) last_exp0 = e.rgb;
        chk($sformatf("u%0d rgb", id), int'(rgb), int'(e.rgb));
        chk($sformatf("u%0d cycles", id), cy, e.n);
        chk($sformatf("u%0d done edge", id), cyc, e.e0 + e.n);
        chk($sformatf("u%0d onehot", id), $countones(rgb), 1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done0, {r0, g0, bl0}, int'(c0));
    mon(1, done1, {r1, g1, bl1}, int'(c1));
    mon(2, done2, {r2, g2, bl2}, int'(c2));
    mon(3, done3, {r3, g3, bl3}, int'(c3));
    mon(4, done4, {r4, g4, bl4}, int'(c4));
  end

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    sb[0].push_back(model(8, 1'b0, 1'b1, a, b, cyc + 1));
    sb[1].push_back(model(8, 1'b1, 1'b1, a, b, cyc + 1));
    sb[2].push_back(model(8, 1'b0, 1'b0, a, b, cyc + 1));
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 5; i++) sb[i].delete();
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 40; t++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 &&
          sb[3].size() == 0 && sb[4].size() == 0) break;
      @(negedge clk);
    end
    if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size() != 0) begin
      chk("done timeout", 1, 0);
      clear_sb();
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; start8 = 1'b1;
    push8(a, b);
    @(negedge clk);
    start8 = 1'b0;
    wait_empty();
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b);
    a2 = a; b2 = b; start2 = 1'b1;
    sb[3].push_back(model(2, 1'b1, 1'b1, {6'd0, a}, {6'd0, b}, cyc + 1));
    sb[4].push_back(model(2, 1'b0, 1'b0, {6'd0, a}, {6'd0, b}, cyc + 1));
    @(negedge clk);
    start2 = 1'b0;
    wait_empty();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, int'({busy0, busy1, busy2, busy3, busy4}), 0);
    chk({tag, " done"}, int'({done0, done1, done2, done3, done4}), 0);
    chk({tag, " rgb"}, int'({r0, g0, bl0}), 0);
    chk({tag, " cycles"}, int'(c0), 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run8(8'h5A, 8'h5A);
    run8(8'h80, 8'h7F);
    run8(8'h12, 8'h13);

    // start pulsed mid-compare with new operands must be ignored
    a8 = 8'hA5; b8 = 8'hA5; start8 = 1'b1;
    push8(8'hA5, 8'hA5);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("midshift busy", int'(busy0), 1);
    chk("midshift hold rgb", int'({r0, g0, bl0}), int'(last_exp0));
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_empty();

    // start held through DONE: back-to-back compare with no IDLE cycle
    a8 = 8'h3C; b8 = 8'h3C; start8 = 1'b1;
    push8(8'h3C, 8'h3C);
    for (int t = 0; t < 20 && !done0; t++) @(negedge clk);
    chk("b2b first done seen", int'(done0), 1);
    a8 = 8'hC1; b8 = 8'h4E;
    push8(8'hC1, 8'h4E);
    @(negedge clk);
    start8 = 1'b0;
    wait_empty();

    // reset at E3 aborts without a done pulse
    a8 = 8'hC3; b8 = 8'hC3; start8 = 1'b1;
    push8(8'hC3, 8'hC3);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run8(8'h01, 8'h02);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run8(ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 16; i++) run2(2'(i >> 2), 2'(i));

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
